// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - single-button A/B/OP load sequencer with held ALU result register
// Optional next-button debounce filter: define ALU_SEQ_DEBOUNCE_EN.
module alu_seq_ctrl #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int DB_CYCLES = 1000000,
    parameter int NB_DBCNT  = $clog2(DB_CYCLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic               i_btn_next,
    input  logic               i_btn_clear,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] next_sync_r, clear_sync_r;
    logic       next_sync, clear_sync;
    logic       next_stable, next_prev, next_pulse;
    logic       load_a, load_b, load_op, capture, show_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sync_r  <= 2'b00;
            clear_sync_r <= 2'b00;
        end else begin
            next_sync_r  <= {next_sync_r[0], i_btn_next};
            clear_sync_r <= {clear_sync_r[0], i_btn_clear};
        end
    end

    assign next_sync  = next_sync_r[1];
    assign clear_sync = clear_sync_r[1];

`ifdef ALU_SEQ_DEBOUNCE_EN
    logic [NB_DBCNT-1:0] db_cnt;
    logic                db_stable;

    // The stable value only follows the synced value after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            db_stable <= 1'b0;
        end else if (next_sync != db_stable) begin
            if (db_cnt == NB_DBCNT'(DB_CYCLES - 1)) begin
                db_stable <= next_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + NB_DBCNT'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign next_stable = db_stable;
`else
    logic unused_cfg;
    assign unused_cfg  = (DB_CYCLES >= 2) && (NB_DBCNT > 0);
    assign next_stable = next_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_prev  <= 1'b0;
            next_pulse <= 1'b0;
        end else begin
            next_prev  <= next_stable;
            next_pulse <= next_stable & ~next_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD_A;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_sync) begin
            state_nxt = S_LOAD_A;
        end else begin
            case (state)
                S_LOAD_A:  if (next_pulse) state_nxt = S_LOAD_B;
                S_LOAD_B:  if (next_pulse) state_nxt = S_LOAD_OP;
                S_LOAD_OP: if (next_pulse) state_nxt = S_EXEC;
                S_EXEC:    state_nxt = S_SHOW;
                S_SHOW:    if (next_pulse) state_nxt = S_LOAD_A;
                default:   state_nxt = S_LOAD_A;
            endcase
        end
    end

    always_comb begin
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        capture   = 1'b0;
        show_exit = 1'b0;
        if (!clear_sync) begin
            load_a    = (state == S_LOAD_A)  && next_pulse;
            load_b    = (state == S_LOAD_B)  && next_pulse;
            load_op   = (state == S_LOAD_OP) && next_pulse;
            capture   = (state == S_EXEC);
            show_exit = (state == S_SHOW)    && next_pulse;
        end
    end

    assign o_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else if (clear_sync) begin
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            if (load_a)  o_alu_a  <= i_sw;
            if (load_b)  o_alu_b  <= i_sw;
            if (load_op) o_alu_op <= i_sw[NB_OP-1:0];
            if (capture) begin
                o_result       <= i_alu_result;
                o_result_valid <= 1'b1;
            end else if (show_exit) begin
                o_result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - vector table plus scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    localparam int HOLD = 12;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_sw;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, result;
    logic [5:0] alu_op;
    logic       result_valid;
    logic [2:0] state;

    int         passed = 0;
    int         total = 0;
    logic [7:0] sb[$];
    logic [2:0] mon_prev = 3'd0;
    vec_t       vecs[7];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_sw(sw), .i_btn_next(btn_next), .i_btn_clear(btn_clear),
        .i_alu_result(alu_result), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .o_result(result), .o_result_valid(result_valid), .o_state(state)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_prev == 3'd3 && state == 3'd4) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_exec", 32'd1, 32'd0);
            end else begin
                check("sb_result", {24'd0, result}, {24'd0, sb.pop_front()});
                check("sb_valid", {31'd0, result_valid}, 32'd1);
            end
        end
        mon_prev <= state;
    end

    task automatic press(input logic [7:0] sw_val);
        @(negedge clk);
        sw = sw_val;
        btn_next = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_next = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_a"}, {24'd0, alu_a}, 32'd0);
        check({tag, "_b"}, {24'd0, alu_b}, 32'd0);
        check({tag, "_op"}, {26'd0, alu_op}, 32'd0);
        check({tag, "_res"}, {24'd0, result}, 32'd0);
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_state"}, {29'd0, state}, 32'd0);
    endtask

    initial begin
        int changes;
        logic [2:0] last;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vecs[1] = '{8'hF0, 8'h20, 8'h22, 6'h22, 8'hD0};
        vecs[2] = '{8'hAA, 8'h0F, 8'h24, 6'h24, 8'h0A};
        vecs[3] = '{8'hA0, 8'h05, 8'h25, 6'h25, 8'hA5};
        vecs[4] = '{8'hFF, 8'h0F, 8'h26, 6'h26, 8'hF0};
        vecs[5] = '{8'h01, 8'h02, 8'hE0, 6'h20, 8'h03};
        vecs[6] = '{8'h80, 8'h80, 8'h20, 6'h20, 8'h00};

        repeat (3) @(posedge clk);
        #1 check_outs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First vector by hand: exact press-to-load latency
        sw = vecs[0].a;
        btn_next = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT - 1) check("lat_before_state", {29'd0, state}, 32'd0);
            if (k == LAT) begin
                check("lat_state", {29'd0, state}, 32'd1);
                check("lat_a", {24'd0, alu_a}, {24'd0, vecs[0].a});
            end
        end
        @(negedge clk);
        btn_next = 1'b0;
        repeat (HOLD) @(negedge clk);
        press(vecs[0].b);
        sb.push_back(vecs[0].exp_res);
        press(vecs[0].op_sw);
        check("t1_a", {24'd0, alu_a}, 32'h05);
        check("t1_b", {24'd0, alu_b}, 32'h03);
        check("t1_op", {26'd0, alu_op}, 32'h20);
        check("t1_state", {29'd0, state}, 32'd4);
        check("t1_result", {24'd0, result}, 32'h08);
        check("t1_valid", {31'd0, result_valid}, 32'd1);
        press(8'h00);

        for (int i = 1; i < 7; i++) begin
            press(vecs[i].a);
            check("vec_a", {24'd0, alu_a}, {24'd0, vecs[i].a});
            press(vecs[i].b);
            check("vec_b", {24'd0, alu_b}, {24'd0, vecs[i].b});
            sb.push_back(vecs[i].exp_res);
            press(vecs[i].op_sw);
            check("vec_op", {26'd0, alu_op}, {26'd0, vecs[i].exp_op});
            check("vec_show_state", {29'd0, state}, 32'd4);
            press(8'h00);
            check("vec_back_state", {29'd0, state}, 32'd0);
            check("vec_back_valid", {31'd0, result_valid}, 32'd0);
            check("vec_held_result", {24'd0, result}, {24'd0, vecs[i].exp_res});
        end

        // Held button: exactly one advance
        changes = 0;
        last = state;
        @(negedge clk);
        sw = 8'h44;
        btn_next = 1'b1;
        for (int k = 0; k < 50 + HOLD; k++) begin
            if (k == 50) btn_next = 1'b0;
            @(negedge clk);
            if (state != last) changes++;
            last = state;
        end
        check("hold_changes", changes, 32'd1);
        check("hold_state", {29'd0, state}, 32'd1);

        // Two-cycle glitch
        @(negedge clk) btn_next = 1'b1;
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
`ifdef ALU_SEQ_DEBOUNCE_EN
        check("glitch_state", {29'd0, state}, 32'd1);
        press(8'h66);
`else
        check("glitch_state", {29'd0, state}, 32'd2);
`endif
        check("pre_clear_state", {29'd0, state}, 32'd2);

        // Clear lands on the same cycle as the next pulse in S_LOAD_OP
        @(negedge clk);
        sw = 8'h3F;
        btn_next = 1'b1;
        repeat (LAT - 3) @(posedge clk);
        #1 btn_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_outs_zero("clear");
        @(negedge clk);
        btn_next = 1'b0;
        btn_clear = 1'b0;
        repeat (HOLD) @(negedge clk);
        check_outs_zero("clear_after");

        // Leaving S_SHOW keeps the result; next load touches A only
        press(8'h05);
        press(8'h03);
        sb.push_back(8'h08);
        press(8'h20);
        check("show_state", {29'd0, state}, 32'd4);
        press(8'h00);
        check("show_exit_state", {29'd0, state}, 32'd0);
        check("show_exit_valid", {31'd0, result_valid}, 32'd0);
        check("show_exit_result", {24'd0, result}, 32'h08);
        press(8'h11);
        check("reload_a", {24'd0, alu_a}, 32'h11);
        check("reload_b", {24'd0, alu_b}, 32'h03);
        check("reload_op", {26'd0, alu_op}, 32'h20);
        check("reload_result", {24'd0, result}, 32'h08);
        check("reload_state", {29'd0, state}, 32'd1);

        // Asynchronous reset mid-cycle in S_LOAD_B
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outs_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", {29'd0, state}, 32'd0);
        check("post_rst_a", {24'd0, alu_a}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
